// File: rtl/des_pkg.sv
// Shared DES tables, FSM state type and key-schedule helpers.
// Every table entry is a DES bit number (1-based). Vectors declared [N:1]
// hold DES bit k at index k, so bit 1 sits at the LSB index.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter holds round-1, so 15 marks the sixteenth round.
  localparam logic [3:0] LAST_ROUND = 4'd15;

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Left-rotation amount applied before round n (entry n-1).
  localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box is stored row-major: entry = row*16 + column.
  localparam int SBOX_TBL [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  // PC-1 on the parity-stripped key: key bit b = 8m+t lives at index 7m+t.
  function automatic logic [56:1] pc1_from_wop(input logic [56:1] key_in);
    logic [56:1] res;
    int          b;
    res = '0;
    for (int k = 1; k <= 56; k++) begin
      b      = PC1_TBL[k-1];
      res[k] = key_in[b - (b - 1) / 8];
    end
    return res;
  endfunction

  // PC-2 selects the 48-bit round key from C||D (C occupies bits 1..28).
  function automatic logic [48:1] pc2(input logic [56:1] cd);
    logic [48:1] res;
    res = '0;
    for (int k = 1; k <= 48; k++) begin
      res[k] = cd[PC2_TBL[k-1]];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_round_engine_f.sv
// Combinational DES round function f(R, K) = P(S1..S8(E(R) xor K)).
module des_round_f
  import des_pkg::*;
(
  input  logic [32:1] half,
  input  logic [48:1] subkey,
  output logic [32:1] result
);

  logic [48:1] expanded;
  logic [48:1] mixed;
  logic [32:1] sbox_out;
  logic [5:0]  sbox_idx;
  logic [3:0]  sbox_val;

  // Expansion E widens the 32-bit half to 48 bits.
  always_comb begin
    expanded = '0;
    for (int k = 1; k <= 48; k++) begin
      expanded[k] = half[E_TBL[k-1]];
    end
  end

  assign mixed = expanded ^ subkey;

  // Eight S-box lookups; row is outer bits b1,b6, column is b2..b5.
  always_comb begin
    sbox_out = '0;
    sbox_idx = '0;
    sbox_val = '0;
    for (int j = 0; j < 8; j++) begin
      sbox_idx = {mixed[6*j+1], mixed[6*j+6], mixed[6*j+2],
                  mixed[6*j+3], mixed[6*j+4], mixed[6*j+5]};
      sbox_val = 4'(SBOX_TBL[j][sbox_idx]);
      sbox_out[4*j+1] = sbox_val[3];
      sbox_out[4*j+2] = sbox_val[2];
      sbox_out[4*j+3] = sbox_val[1];
      sbox_out[4*j+4] = sbox_val[0];
    end
  end

  // Permutation P on the concatenated S-box outputs.
  always_comb begin
    result = '0;
    for (int k = 1; k <= 32; k++) begin
      result[k] = sbox_out[P_TBL[k-1]];
    end
  end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES round engine: one Feistel round per clock, 17 cycles per
// block, with a single shared f-function instance.
module des_round_engine
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [32:1] data_l,
  input  logic [32:1] data_r,
  input  logic [56:1] key_wop,
  output logic        busy,
  output logic        done,
  output logic [32:1] pre_l,
  output logic [32:1] pre_r
);

  state_t      state;
  state_t      state_next;
  logic [3:0]  round_cnt;
  logic [32:1] l_half;
  logic [32:1] r_half;
  logic [28:1] c_half;
  logic [28:1] d_half;
  logic [28:1] c_rot;
  logic [28:1] d_rot;
  logic [56:1] cd_init;
  logic [48:1] round_key;
  logic [32:1] f_out;
  logic        accept;
  logic        last_round;

  // DONE accepts a new block exactly like IDLE, enabling back-to-back use.
  assign accept     = start && (state == IDLE || state == DONE);
  assign last_round = (state == RUN) && (round_cnt == LAST_ROUND);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; start is ignored while rounds execute.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (round_cnt == LAST_ROUND) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Round counter saturates at the last round so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      round_cnt <= '0;
    else if (accept)                                 round_cnt <= '0;
    else if (state == RUN && round_cnt != LAST_ROUND) round_cnt <= round_cnt + 4'd1;
  end

  assign cd_init = pc1_from_wop(key_wop);

  // Rotate C and D toward bit 1 by the scheduled amount for this round.
  always_comb begin
    if (SHIFT_TBL[round_cnt] == 1) begin
      c_rot = {c_half[1], c_half[28:2]};
      d_rot = {d_half[1], d_half[28:2]};
    end else begin
      c_rot = {c_half[2:1], c_half[28:3]};
      d_rot = {d_half[2:1], d_half[28:3]};
    end
  end

  // D is placed in the upper indices so that C fills DES bits 1..28.
  assign round_key = pc2({d_rot, c_rot});

  des_round_f u_round_f (
    .half   (r_half),
    .subkey (round_key),
    .result (f_out)
  );

  // Working halves and key registers: load on accept, one round per RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_half <= '0;
      r_half <= '0;
      c_half <= '0;
      d_half <= '0;
    end else if (accept) begin
      l_half <= data_l;
      r_half <= data_r;
      c_half <= cd_init[28:1];
      d_half <= cd_init[56:29];
    end else if (state == RUN) begin
      l_half <= r_half;
      r_half <= l_half ^ f_out;
      c_half <= c_rot;
      d_half <= d_rot;
    end
  end

  // Capture the swapped preoutput on the sixteenth round edge and hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_l <= '0;
      pre_r <= '0;
    end else if (last_round) begin
      pre_l <= l_half ^ f_out;
      pre_r <= r_half;
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// Directed self-checking bench for des_round_engine. Hex constants are in
// the usual DES notation (bit 1 = MSB); port vectors carry DES bit k at
// index k, so values are bit-reversed when crossing the boundary.
module tb_des_round_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [32:1] data_l;
  logic [32:1] data_r;
  logic [56:1] key_wop;
  logic        busy;
  logic        done;
  logic [32:1] pre_l;
  logic [32:1] pre_r;

  int num_checks = 0;
  int num_errors = 0;

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
  localparam logic [31:0] FIPS_L0  = 32'hCC00CCFF;
  localparam logic [31:0] FIPS_R0  = 32'hF0AAF0AA;
  localparam logic [31:0] FIPS_R16 = 32'h0A4CD995;
  localparam logic [31:0] FIPS_L16 = 32'h43423234;
  localparam logic [47:0] FIPS_K1  = 48'h1B02EFFC7072;
  localparam logic [31:0] FIPS_L1  = 32'hF0AAF0AA;
  localparam logic [31:0] FIPS_R1  = 32'hEF4A6544;
  // All-zero key/plaintext encrypts to 8CA64DE9C1B123A7; IP of that is R16||L16.
  localparam logic [31:0] ZERO_R16 = 32'h1C2087FC;
  localparam logic [31:0] ZERO_L16 = 32'hBBEA0DC2;

  des_round_engine dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_l  (data_l),
    .data_r  (data_r),
    .key_wop (key_wop),
    .busy    (busy),
    .done    (done),
    .pre_l   (pre_l),
    .pre_r   (pre_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] swap32(input logic [31:0] v);
    logic [31:0] s;
    for (int i = 0; i < 32; i++) s[31-i] = v[i];
    return s;
  endfunction

  function automatic logic [47:0] swap48(input logic [47:0] v);
    logic [47:0] s;
    for (int i = 0; i < 48; i++) s[47-i] = v[i];
    return s;
  endfunction

  // Strip parity: wop index j carries DES key bit j + (j-1)/7.
  function automatic logic [55:0] make_wop(input logic [63:0] key);
    logic [55:0] w;
    int          b;
    w = '0;
    for (int j = 1; j <= 56; j++) begin
      b      = j + (j - 1) / 7;
      w[j-1] = key[64-b];
    end
    return w;
  endfunction

  task automatic load_block(input logic [63:0] key, input logic [31:0] l0, input logic [31:0] r0);
    key_wop = make_wop(key);
    data_l  = swap32(l0);
    data_r  = swap32(r0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b1;
    start   = 1'b0;
    data_l  = '0;
    data_r  = '0;
    key_wop = '0;
    #2 rst_n = 1'b0;
    tick();
    num_checks++;
    if (busy !== 1'b0) begin num_errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    num_checks++;
    if (done !== 1'b0) begin num_errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    num_checks++;
    if (pre_l !== 32'h0) begin num_errors++; $display("[TB] FAIL reset_pre_l: got %h expected 0", pre_l); end
    num_checks++;
    if (pre_r !== 32'h0) begin num_errors++; $display("[TB] FAIL reset_pre_r: got %h expected 0", pre_r); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      num_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        num_errors++;
        $display("[TB] FAIL idle_status: got busy=%b done=%b expected 0 0", busy, done);
      end
    end
  endtask

  task automatic test_fips;
    load_block(FIPS_KEY, FIPS_L0, FIPS_R0);
    start = 1'b1;
    tick();
    start = 1'b0;
    data_l  = 32'h5A5A_1234;
    data_r  = 32'hFFFF_0000;
    key_wop = 56'hAB_CDEF_0123_4567;
    num_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL fips_accept: got busy=%b done=%b expected 1 0", busy, done);
    end
    for (int n = 1; n <= 15; n++) begin
      tick();
      num_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        num_errors++;
        $display("[TB] FAIL fips_round%0d_status: got busy=%b done=%b expected 1 0", n, busy, done);
      end
    end
    tick();
    num_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL fips_done: got busy=%b done=%b expected 0 1", busy, done);
    end
    num_checks++;
    if (swap32(pre_l) !== FIPS_R16) begin num_errors++; $display("[TB] FAIL fips_pre_l: got %h expected %h", swap32(pre_l), FIPS_R16); end
    num_checks++;
    if (swap32(pre_r) !== FIPS_L16) begin num_errors++; $display("[TB] FAIL fips_pre_r: got %h expected %h", swap32(pre_r), FIPS_L16); end
    tick();
    num_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL fips_after_done: got busy=%b done=%b expected 0 0", busy, done);
    end
    num_checks++;
    if (swap32(pre_l) !== FIPS_R16 || swap32(pre_r) !== FIPS_L16) begin
      num_errors++;
      $display("[TB] FAIL fips_hold: got %h %h expected %h %h", swap32(pre_l), swap32(pre_r), FIPS_R16, FIPS_L16);
    end
  endtask

  task automatic test_round1;
    load_block(FIPS_KEY, FIPS_L0, FIPS_R0);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Key presented to the first round edge.
    num_checks++;
    if (swap48(dut.round_key) !== FIPS_K1) begin
      num_errors++;
      $display("[TB] FAIL round1_key: got %h expected %h", swap48(dut.round_key), FIPS_K1);
    end
    tick();
    num_checks++;
    if (swap32(dut.l_half) !== FIPS_L1) begin num_errors++; $display("[TB] FAIL round1_l: got %h expected %h", swap32(dut.l_half), FIPS_L1); end
    num_checks++;
    if (swap32(dut.r_half) !== FIPS_R1) begin num_errors++; $display("[TB] FAIL round1_r: got %h expected %h", swap32(dut.r_half), FIPS_R1); end
    for (int c = 3; c <= 17; c++) begin
      tick();
      num_checks++;
      if (done !== (c == 17)) begin num_errors++; $display("[TB] FAIL round1_done_c%0d: got %b expected %b", c, done, (c == 17)); end
    end
    num_checks++;
    if (swap32(pre_l) !== FIPS_R16) begin num_errors++; $display("[TB] FAIL round1_pre_l: got %h expected %h", swap32(pre_l), FIPS_R16); end
    tick();
  endtask

  task automatic test_zero;
    load_block(64'h0, 32'h0, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 18; c++) begin
      tick();
      num_checks++;
      if (done !== (c == 17)) begin num_errors++; $display("[TB] FAIL zero_done_c%0d: got %b expected %b", c, done, (c == 17)); end
      if (c == 17) begin
        num_checks++;
        if (swap32(pre_l) !== ZERO_R16) begin num_errors++; $display("[TB] FAIL zero_pre_l: got %h expected %h", swap32(pre_l), ZERO_R16); end
        num_checks++;
        if (swap32(pre_r) !== ZERO_L16) begin num_errors++; $display("[TB] FAIL zero_pre_r: got %h expected %h", swap32(pre_r), ZERO_L16); end
      end
    end
  endtask

  task automatic test_start_during_run;
    load_block(FIPS_KEY, FIPS_L0, FIPS_R0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      start = (c == 5);
      num_checks++;
      if (done !== (c == 17)) begin num_errors++; $display("[TB] FAIL ignore_start_done_c%0d: got %b expected %b", c, done, (c == 17)); end
      if (c == 17) begin
        num_checks++;
        if (swap32(pre_l) !== FIPS_R16 || swap32(pre_r) !== FIPS_L16) begin
          num_errors++;
          $display("[TB] FAIL ignore_start_result: got %h %h expected %h %h", swap32(pre_l), swap32(pre_r), FIPS_R16, FIPS_L16);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic exp_done;
    load_block(FIPS_KEY, FIPS_L0, FIPS_R0);
    start = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      tick();
      if (c == 40) start = 1'b0;
      exp_done = (c == 17 || c == 34 || c == 51);
      num_checks++;
      if (done !== exp_done) begin num_errors++; $display("[TB] FAIL b2b_done_c%0d: got %b expected %b", c, done, exp_done); end
      num_checks++;
      if (busy !== (c <= 51 && !exp_done)) begin
        num_errors++;
        $display("[TB] FAIL b2b_busy_c%0d: got %b expected %b", c, busy, (c <= 51 && !exp_done));
      end
      if (exp_done) begin
        num_checks++;
        if (swap32(pre_l) !== FIPS_R16) begin num_errors++; $display("[TB] FAIL b2b_pre_l_c%0d: got %h expected %h", c, swap32(pre_l), FIPS_R16); end
      end
    end
  endtask

  task automatic test_reset_during_run;
    load_block(FIPS_KEY, FIPS_L0, FIPS_R0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 9; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    num_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      num_errors++;
      $display("[TB] FAIL abort_status: got busy=%b done=%b expected 0 0", busy, done);
    end
    num_checks++;
    if (pre_l !== 32'h0 || pre_r !== 32'h0) begin
      num_errors++;
      $display("[TB] FAIL abort_pre: got %h %h expected 0 0", pre_l, pre_r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      num_checks++;
      if (done !== 1'b0 || pre_l !== 32'h0 || pre_r !== 32'h0) begin
        num_errors++;
        $display("[TB] FAIL abort_quiet_c%0d: got done=%b pre=%h %h expected 0", c, done, pre_l, pre_r);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    num_checks++;
    if (busy !== 1'b1) begin num_errors++; $display("[TB] FAIL first_start: got busy=%b expected 1", busy); end
    for (int c = 2; c <= 17; c++) begin
      tick();
      num_checks++;
      if (done !== (c == 17)) begin num_errors++; $display("[TB] FAIL restart_done_c%0d: got %b expected %b", c, done, (c == 17)); end
      if (c < 17) begin
        num_checks++;
        if (pre_l !== 32'h0 || pre_r !== 32'h0) begin
          num_errors++;
          $display("[TB] FAIL restart_pre_zero_c%0d: got %h %h expected 0 0", c, pre_l, pre_r);
        end
      end
    end
    num_checks++;
    if (swap32(pre_l) !== FIPS_R16 || swap32(pre_r) !== FIPS_L16) begin
      num_errors++;
      $display("[TB] FAIL restart_result: got %h %h expected %h %h", swap32(pre_l), swap32(pre_r), FIPS_R16, FIPS_L16);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fips();
    test_round1();
    test_zero();
    test_start_during_run();
    test_back_to_back();
    test_reset_during_run();
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
